// File: rtl/npu_cube_pkg.sv
// Shared types and index helpers for the NPU cube Booth partial-product path.
package npu_cube_pkg;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_code_t;

  localparam int BOOTH_W = 3;

  // One extra digit beyond DWB/2 absorbs the zero-extended top bit in unsigned mode.
  function automatic int pp_num_f(input int dwb);
    return dwb / 2 + 1;
  endfunction

  // Two guard bits hold 2A and its complement without overflow.
  function automatic int ppw_f(input int dwa);
    return dwa + 2;
  endfunction

  function automatic int lane_digit(input int lane, input int digit, input int pp_num);
    return lane * pp_num + digit;
  endfunction

  function automatic booth_code_t booth_enc(input logic [2:0] trip);
    booth_code_t c;
    case (trip)
      3'b001, 3'b010: c = '{neg: 1'b0, one: 1'b1, two: 1'b0};
      3'b011:         c = '{neg: 1'b0, one: 1'b0, two: 1'b1};
      3'b100:         c = '{neg: 1'b1, one: 1'b0, two: 1'b1};
      3'b101, 3'b110: c = '{neg: 1'b1, one: 1'b1, two: 1'b0};
      default:        c = '{neg: 1'b0, one: 1'b0, two: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/npu_booth_pp_lane.sv
// One MAC lane: selects 0/A/2A per pre-encoded Booth digit and applies one's complement.
module npu_booth_pp_lane
  import npu_cube_pkg::*;
#(
  parameter int DWA    = 8,
  parameter int DWB    = 8,
  parameter int PP_NUM = pp_num_f(DWB),
  parameter int PPW    = ppw_f(DWA)
) (
  input  logic [DWA-1:0]            a,
  input  logic [PP_NUM*BOOTH_W-1:0] code,
  input  logic                      mode,
  output logic [PP_NUM*PPW-1:0]     pp,
  output logic [PP_NUM-1:0]         neg
);

  logic [PPW-1:0] a_ext;
  logic [PPW-1:0] a_x2;

  assign a_ext = mode ? {{2{a[DWA-1]}}, a} : {2'b00, a};
  assign a_x2  = {a_ext[PPW-2:0], 1'b0};

  for (genvar k = 0; k < PP_NUM; k++) begin : g_dig
    booth_code_t    c;
    logic [PPW-1:0] mag;

    assign c   = booth_code_t'(code[k*BOOTH_W +: BOOTH_W]);
    assign mag = c.two ? a_x2 : (c.one ? a_ext : '0);
    assign pp[k*PPW +: PPW] = c.neg ? ~mag : mag;
    // A zero digit never carries a correction bit into the tree.
    assign neg[k] = c.neg & (c.one | c.two);
  end

endmodule

// File: rtl/npu_cube_booth_pp_pipe.sv
// Weight-stationary Booth partial-product generator with a 2-stage valid/ready pipe.
module npu_cube_booth_pp_pipe
  import npu_cube_pkg::*;
#(
  parameter int DWA     = 8,
  parameter int DWB     = 8,
  parameter int MAC_NUM = 8,
  parameter int PP_NUM  = pp_num_f(DWB),
  parameter int PPW     = ppw_f(DWA)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          para_load,
  output logic                          para_ready,
  input  logic [DWB*MAC_NUM-1:0]        para_in,
  input  logic                          para_signed,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DWA*MAC_NUM-1:0]        in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PPW*PP_NUM*MAC_NUM-1:0] out_pp,
  output logic [PP_NUM*MAC_NUM-1:0]     out_neg
);

  localparam int CODE_W = PP_NUM * BOOTH_W;

  logic [DWB*MAC_NUM-1:0]        wgt_q;
  logic                          mode_q;
  logic [CODE_W*MAC_NUM-1:0]     code_q;
  logic [CODE_W*MAC_NUM-1:0]     code_d;
  logic [DWB*MAC_NUM-1:0]        wgt_src;
  logic                          mode_src;
  logic                          load_acc;
  logic                          en;
  logic                          s1_valid;
  logic [DWA*MAC_NUM-1:0]        s1_data;
  logic [PPW*PP_NUM*MAC_NUM-1:0] pp_d;
  logic [PP_NUM*MAC_NUM-1:0]     neg_d;

  assign en         = !out_valid | out_ready;
  assign in_ready   = en & !para_load;
  assign para_ready = !s1_valid & !out_valid;
  assign load_acc   = para_load & para_ready;

  // Encoder sees incoming weights on the load edge, otherwise re-encodes the stored
  // weights, so codes always track the weight register.
  assign wgt_src  = load_acc ? para_in : wgt_q;
  assign mode_src = load_acc ? para_signed : mode_q;

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_enc
    logic [DWB+2:0] b_pad;

    assign b_pad = {(mode_src ? {2{wgt_src[i*DWB+DWB-1]}} : 2'b00),
                    wgt_src[i*DWB +: DWB], 1'b0};

    for (genvar k = 0; k < PP_NUM; k++) begin : g_dig
      assign code_d[lane_digit(i, k, PP_NUM)*BOOTH_W +: BOOTH_W] = booth_enc(b_pad[2*k +: 3]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wgt_q  <= '0;
      mode_q <= 1'b0;
      code_q <= '0;
    end else begin
      code_q <= code_d;
      if (load_acc) begin
        wgt_q  <= para_in;
        mode_q <= para_signed;
      end
    end
  end

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    npu_booth_pp_lane #(
      .DWA    (DWA),
      .DWB    (DWB),
      .PP_NUM (PP_NUM),
      .PPW    (PPW)
    ) u_lane (
      .a    (s1_data[i*DWA +: DWA]),
      .code (code_q[i*CODE_W +: CODE_W]),
      .mode (mode_q),
      .pp   (pp_d[lane_digit(i, 0, PP_NUM)*PPW +: PP_NUM*PPW]),
      .neg  (neg_d[lane_digit(i, 0, PP_NUM) +: PP_NUM])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_pp    <= '0;
      out_neg   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid & in_ready;
      s1_data   <= in_data;
      out_valid <= s1_valid;
      out_pp    <= pp_d;
      out_neg   <= neg_d;
    end
  end

endmodule
